// File: rtl/store_narrow_buf_if.sv
// Store request / data-memory drain bus for store_narrow_buf.
// The master issues stores and acts as the memory side. The slave is the buffer.
interface store_narrow_buf_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  SOp;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        empty;
    logic        misalign;

    modport master (
        output in_valid, SOp, addr, wdata, mem_ready,
        input  in_ready, mem_valid, mem_addr, mem_wdata, mem_be, empty, misalign
    );

    modport slave (
        input  in_valid, SOp, addr, wdata, mem_ready,
        output in_ready, mem_valid, mem_addr, mem_wdata, mem_be, empty, misalign
    );
endinterface

// File: rtl/store_narrow_buf.sv
// Narrows 32-bit store data to byte/half/word lanes and queues it in a small FIFO drained to DM.
// Define STORE_MERGE_EN to merge a store into the newest entry when it targets the same word.
module store_narrow_buf #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input logic             clk,
    input logic             reset,
    store_narrow_buf_if.slave bus
);

    typedef struct packed {
        logic [29:0] word;
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);

    entry_t           buf_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             misalign_q;

    logic        legal, accept, push, pop, merge, alloc;
    logic [31:0] new_data;
    logic [3:0]  new_be;
    entry_t      head;

    always_comb begin
        new_data = bus.wdata;
        new_be   = 4'b1111;
        legal    = 1'b0;
        case (bus.SOp)
            2'b00: legal = (bus.addr[1:0] == 2'b00);
            2'b01: begin
                new_data = {2{bus.wdata[15:0]}};
                new_be   = bus.addr[1] ? 4'b1100 : 4'b0011;
                legal    = !bus.addr[0];
            end
            2'b10: begin
                new_data = {4{bus.wdata[7:0]}};
                new_be   = 4'b0001 << bus.addr[1:0];
                legal    = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && legal;
    assign pop    = bus.mem_valid && bus.mem_ready;
    assign alloc  = push && !merge;

`ifdef STORE_MERGE_EN
    logic [PTR_W-1:0] tail_ptr;
    entry_t           tail, merged;

    // The tail is off limits when it is also the head leaving this cycle.
    always_comb begin
        tail_ptr  = wr_ptr - 1'b1;
        tail      = buf_q[tail_ptr];
        merged    = tail;
        merged.be = tail.be | new_be;
        for (int b = 0; b < 4; b++) begin
            if (new_be[b]) merged.data[8*b +: 8] = new_data[8*b +: 8];
        end
        merge = push && (count != '0) && (tail.word == bus.addr[31:2])
                && !(pop && count == CNT_ONE);
    end
`else
    assign merge = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the entry array is reset too, because the head entry drives mem_* directly
            // and those outputs must read zero straight out of reset.
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= accept && !legal;
            if (alloc) begin
                buf_q[wr_ptr] <= '{word: bus.addr[31:2], data: new_data, be: new_be};
                wr_ptr        <= wr_ptr + 1'b1;
            end
`ifdef STORE_MERGE_EN
            if (merge) buf_q[tail_ptr] <= merged;
`endif
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({alloc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head          = buf_q[rd_ptr];
    assign bus.in_ready  = (count != CNT_FULL);
    assign bus.mem_valid = (count != '0);
    assign bus.empty     = (count == '0);
    assign bus.misalign  = misalign_q;
    assign bus.mem_addr  = {head.word, 2'b00};
    assign bus.mem_wdata = head.data;
    assign bus.mem_be    = head.be;

endmodule

// File: tb/tb_store_narrow_buf.sv
// Randomized bench for store_narrow_buf against a queue-based store-buffer model, with directed
// literal checks that pin the model. Honours STORE_MERGE_EN the same way the design does.
module tb_store_narrow_buf;

    localparam int DEPTH = 4;
`ifdef STORE_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    typedef struct {
        logic [29:0] word;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    store_narrow_buf_if bus ();

    store_narrow_buf #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;
    ent_t q[$];
    bit   exp_mis = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void narrow(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] w, output bit ok,
                                   output logic [31:0] d, output logic [3:0] be);
        ok = 1'b0; d = w; be = 4'h0;
        case (op)
            2'd0: begin ok = (a % 4) == 0; d = w; be = 4'hF; end
            2'd1: begin
                ok = (a % 2) == 0;
                d  = (w & 32'h0000FFFF) * 32'h00010001;
                be = ((a % 4) >= 2) ? 4'hC : 4'h3;
            end
            2'd2: begin
                ok = 1'b1;
                d  = (w & 32'h000000FF) * 32'h01010101;
                be = 4'(1 << (a % 4));
            end
            default: ok = 1'b0;
        endcase
    endfunction

    // Model step for one rising edge, using the inputs held across that edge.
    function automatic void model_step();
        bit          ok, pop, acc, mrg;
        logic [31:0] d;
        logic [3:0]  be;
        ent_t        t;
        if (reset) begin
            q.delete();
            exp_mis = 1'b0;
            return;
        end
        narrow(bus.SOp, bus.addr, bus.wdata, ok, d, be);
        pop     = (q.size() > 0) && bus.mem_ready;
        acc     = bus.in_valid && (q.size() < DEPTH);
        exp_mis = acc && !ok;
        mrg     = MERGE && acc && ok && (q.size() > 0)
                  && (q[q.size()-1].word == 30'(bus.addr / 4))
                  && !(pop && q.size() == 1);
        if (mrg) begin
            t = q[q.size()-1];
            t.be = t.be | be;
            for (int b = 0; b < 4; b++) if (be[b]) t.data[8*b +: 8] = d[8*b +: 8];
            q[q.size()-1] = t;
        end
        if (pop) void'(q.pop_front());
        if (acc && ok && !mrg) q.push_back('{word: 30'(bus.addr / 4), data: d, be: be});
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready",  bus.in_ready,  q.size() != DEPTH);
            check("mem_valid", bus.mem_valid, q.size() != 0);
            check("empty",     bus.empty,     q.size() == 0);
            check("misalign",  bus.misalign,  exp_mis);
            if (q.size() != 0) begin
                check("mem_addr",  bus.mem_addr,  {q[0].word, 2'b00});
                check("mem_wdata", bus.mem_wdata, q[0].data);
                check("mem_be",    bus.mem_be,    q[0].be);
            end
        end
    end

    task automatic drive(input bit v, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] w);
        bus.in_valid = v;
        bus.SOp      = op;
        bus.addr     = a;
        bus.wdata    = w;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(output int pops);
        pops = 0;
        bus.mem_ready = 1'b1;
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        for (int i = 0; i < 2 * DEPTH && bus.mem_valid; i++) begin
            tick();
            pops++;
        end
        check("drain_done", bus.empty, 1'b1);
    endtask

    initial begin
        int pops;
        reset         = 1'b1;
        bus.mem_ready = 1'b0;
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        @(negedge clk);
        do_reset();
        chk_en = 1'b1;
        check("rst_in_ready",  bus.in_ready,  1'b1);
        check("rst_mem_valid", bus.mem_valid, 1'b0);
        check("rst_empty",     bus.empty,     1'b1);
        check("rst_misalign",  bus.misalign,  1'b0);
        check("rst_mem_addr",  bus.mem_addr,  32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_mem_be",    bus.mem_be,    32'h0);

        // sb to the top byte lane, drained immediately
        bus.mem_ready = 1'b1;
        drive(1'b1, 2'd2, 32'h0000_1003, 32'h0000_00AB);
        tick();
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        check("t1_valid", bus.mem_valid, 1'b1);
        check("t1_addr",  bus.mem_addr,  32'h0000_1000);
        check("t1_be",    bus.mem_be,    32'h8);
        check("t1_wdata", bus.mem_wdata, 32'hABAB_ABAB);
        tick();
        check("t1_empty", bus.empty, 1'b1);

        // upper half-word, then a misaligned half-word that must not allocate
        bus.mem_ready = 1'b0;
        drive(1'b1, 2'd1, 32'h0000_2002, 32'h0000_1234);
        tick();
        check("t2_be",    bus.mem_be,    32'hC);
        check("t2_wdata", bus.mem_wdata, 32'h1234_1234);
        drive(1'b1, 2'd1, 32'h0000_2001, 32'h0000_5678);
        tick();
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        check("t2_misalign", bus.misalign, 1'b1);
        tick();
        check("t2_mis_clear", bus.misalign, 1'b0);
        drain(pops);
        check("t2_count", pops, 1);

        // fill to full, then drain in order
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd0, 32'(4 * i), 32'hC0DE_0000 + 32'(i));
            tick();
        end
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        check("t3_full", bus.in_ready, 1'b0);
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t3_order", bus.mem_addr, 32'(4 * i));
            tick();
        end
        check("t3_empty", bus.empty, 1'b1);

        // steady push+pop at count 2 for six cycles, wrapping the pointers
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'd0, 32'h100 + 32'(4 * i), 32'(i));
            tick();
        end
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("t4_head", bus.mem_addr, 32'h100 + 32'(4 * i));
            drive(1'b1, 2'd0, 32'h108 + 32'(4 * i), 32'(i + 2));
            tick();
        end
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        check("t4_head_a", bus.mem_addr, 32'h118);
        tick();
        check("t4_head_b", bus.mem_addr, 32'h11C);
        tick();
        check("t4_empty", bus.empty, 1'b1);

        // two byte stores to the same word
        bus.mem_ready = 1'b0;
        drive(1'b1, 2'd2, 32'h40, 32'h11);
        tick();
        drive(1'b1, 2'd2, 32'h41, 32'h22);
        tick();
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        check("t5_be",    bus.mem_be,    MERGE ? 32'h3 : 32'h1);
        check("t5_wdata", bus.mem_wdata, MERGE ? 32'h1111_2211 : 32'h1111_1111);
        drain(pops);
        check("t5_count", pops, MERGE ? 1 : 2);

        // reset while holding three entries
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd0, 32'h200 + 32'(4 * i), 32'hFFFF_0000);
            tick();
        end
        do_reset();
        check("t6_empty",    bus.empty,     1'b1);
        check("t6_valid",    bus.mem_valid, 1'b0);
        check("t6_in_ready", bus.in_ready,  1'b1);

        // random traffic over a few words so merges, wraps and full stalls all occur
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 199) == 0);
            bus.mem_ready = ($urandom_range(0, 99) < 45);
            drive($urandom_range(0, 99) < 70, 2'($urandom_range(0, 3)),
                  32'h0000_3000 + 32'($urandom_range(0, 15)), $urandom());
            tick();
        end
        reset = 1'b0;
        drain(pops);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
